mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_map_pkg.sv | 45 ++++
 rtl/mem_responder_if.sv | 15 +
 rtl/dmem_ram.sv | 21 ++
 rtl/mem_responder.sv | 112 +++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Shared address map for the data-memory responder: RAM/MMIO bases,
// register offsets, STAT bit index and a helper that decodes a byte address.
package mem_map_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IO_W   = 8;

  localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

  localparam logic [31:0] OFS_LED   = 32'h0000_0000;
  localparam logic [31:0] OFS_SW    = 32'h0000_0004;
  localparam logic [31:0] OFS_CYCLE = 32'h0000_0008;
  localparam logic [31:0] OFS_CMP   = 32'h0000_000C;
  localparam logic [31:0] OFS_STAT  = 32'h0000_0010;

  localparam int unsigned STAT_MATCH_BIT = 0;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_SW,
    SEL_CYCLE,
    SEL_CMP,
    SEL_STAT
  } sel_e;

  // Word-granular decode; the two byte-offset bits never affect the target.
  function automatic sel_e decode_addr(input logic [31:0] addr,
                                       input logic [31:0] ram_bytes);
    logic [31:0] word_addr;
    sel_e        sel;
    word_addr = {addr[31:2], 2'b00};
    sel       = SEL_NONE;
    if ((word_addr - RAM_BASE) < ram_bytes)        sel = SEL_RAM;
    else if (word_addr == (MMIO_BASE + OFS_LED))   sel = SEL_LED;
    else if (word_addr == (MMIO_BASE + OFS_SW))    sel = SEL_SW;
    else if (word_addr == (MMIO_BASE + OFS_CYCLE)) sel = SEL_CYCLE;
    else if (word_addr == (MMIO_BASE + OFS_CMP))   sel = SEL_CMP;
    else if (word_addr == (MMIO_BASE + OFS_STAT))  sel = SEL_STAT;
    return sel;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Core-side load/store bus: the core (master) drives strobe, address and
// store data; the responder (slave) returns combinational load data.
interface mem_responder_if;
  import mem_map_pkg::*;

  logic              MemWrite;
  logic [DATA_W-1:0] ALUResult;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadData;

  modport master (output MemWrite, output ALUResult, output WriteData,
                  input  ReadData);
  modport slave  (input  MemWrite, input  ALUResult, input  WriteData,
                  output ReadData);
endinterface

// File: rtl/dmem_ram.sv
// Data RAM: synchronous write, asynchronous read, contents never reset.
module dmem_ram #(
  parameter int unsigned WORDS = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(WORDS)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [WORDS];

  // Store commits on the rising edge; no reset so data survives a reset pulse.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder for a single-cycle core: RAM plus LED, switch,
// free-running cycle counter and an optional compare timer.
// Optional feature: define MEM_RESPONDER_TIMER_EN to build CMP, STAT and
// TimerIrq; otherwise they read 0, ignore writes and TimerIrq is tied low.
module mem_responder
  import mem_map_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 64
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus,
  input  logic [IO_W-1:0] Switches,
  output logic [IO_W-1:0] Leds,
  output logic            TimerIrq
);

  localparam int unsigned RAM_AW    = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

  sel_e              sel;
  logic              wr_en;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic [IO_W-1:0]   sw_meta;
  logic [IO_W-1:0]   sw_sync;
  logic [IO_W-1:0]   led_q;
  logic [DATA_W-1:0] cycle_q;
  logic              unused_addr_lsb;

  // Stores are dropped while reset is held, including into the unreset RAM.
  assign wr_en           = bus.MemWrite & reset;
  assign sel             = decode_addr(bus.ALUResult, RAM_BYTES);
  assign ram_we          = wr_en && (sel == SEL_RAM);
  assign unused_addr_lsb = ^bus.ALUResult[1:0];

  // RAM sits at address zero, so the word index is taken straight from the address.
  dmem_ram #(.WORDS(RAM_WORDS)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (bus.ALUResult[RAM_AW+1:2]),
    .wdata (bus.WriteData),
    .rdata (ram_rdata)
  );

  // Two-flop synchronizer for the asynchronous board switches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= Switches;
      sw_sync <= sw_meta;
    end
  end

  // LED register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         led_q <= '0;
    else if (wr_en && sel == SEL_LED)   led_q <= bus.WriteData[IO_W-1:0];
  end

  assign Leds = led_q;

  // Free-running cycle counter; any write clears it and beats the increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         cycle_q <= '0;
    else if (wr_en && sel == SEL_CYCLE) cycle_q <= '0;
    else                                cycle_q <= cycle_q + 32'd1;
  end

`ifdef MEM_RESPONDER_TIMER_EN
  logic [DATA_W-1:0] cmp_q;
  logic              match_q;
  logic              stat_clr;

  assign stat_clr = wr_en && (sel == SEL_STAT) && bus.WriteData[STAT_MATCH_BIT];

  // Compare value; a new value is used for matching from the next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       cmp_q <= 32'hFFFF_FFFF;
    else if (wr_en && sel == SEL_CMP) cmp_q <= bus.WriteData;
  end

  // Sticky match flag; a new match beats a simultaneous write-1-clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) match_q <= 1'b0;
    else        match_q <= (cycle_q == cmp_q) | (match_q & ~stat_clr);
  end

  assign TimerIrq = match_q;
`else
  assign TimerIrq = 1'b0;
`endif

  // Zero-latency load mux; unmapped and disabled registers read as zero.
  always_comb begin
    bus.ReadData = '0;
    case (sel)
      SEL_RAM:   bus.ReadData = ram_rdata;
      SEL_LED:   bus.ReadData = DATA_W'(led_q);
      SEL_SW:    bus.ReadData = DATA_W'(sw_sync);
      SEL_CYCLE: bus.ReadData = cycle_q;
`ifdef MEM_RESPONDER_TIMER_EN
      SEL_CMP:   bus.ReadData = cmp_q;
      SEL_STAT:  bus.ReadData = DATA_W'(match_q) << STAT_MATCH_BIT;
`endif
      default:   bus.ReadData = '0;
    endcase
  end

endmodule
